// File: rtl/ozixe_cfg_loader_pkg.sv
// Shared types and constants for the OZIXE configuration frame loader.
// Holds the loader state encoding, the frame constants and the CRC-16 byte step.
package ozixe_cfg_pkg;

    typedef enum logic [2:0] {
        HUNT,
        HDR,
        DATA,
        CRC,
        DONE,
        ERR
    } state_e;

    localparam logic [31:0] SYNC_WORD_DEF = 32'hA5C3_0E1F;
    localparam logic [15:0] CRC_POLY      = 16'h1021;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ADDR_OVF = 2'd1;
    localparam logic [1:0] ERR_CRC      = 2'd2;

    // CRC-16-CCITT, MSB first, one byte folded into the top of the register.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ozixe_cfg_loader_if.sv
// Byte-stream input and config-memory write bus of the loader.
// The loader takes the slave view; the stream source / memory side takes the master view.
interface ozixe_cfg_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) ();

    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  cfg_addr,
        input  cfg_wdata,
        input  cfg_valid,
        output cfg_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output cfg_addr,
        output cfg_wdata,
        output cfg_valid,
        input  cfg_ready
    );

endinterface

// File: rtl/ozixe_cfg_loader_crc16.sv
// Combinational CRC-16-CCITT step over one stream byte.
// The running CRC register lives in the loader.
module ozixe_crc16_byte
    import ozixe_cfg_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    assign crc_out = crc16_update(crc_in, data_in);

endmodule

// File: rtl/ozixe_cfg_loader.sv
// OZIXE configuration frame loader: hunts the sync word, parses the header, packs
// payload bytes into words, writes them to tile config memory and checks the frame CRC.
module ozixe_cfg_loader
    import ozixe_cfg_pkg::*;
#(
    parameter int          CFG_ADDR_W = 16,
    parameter int          CFG_DATA_W = 32,
    parameter logic [31:0] SYNC_WORD  = SYNC_WORD_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    ozixe_cfg_loader_if.slave   bus,
    input  logic                restart,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code
);

    localparam logic [32:0] ADDR_LIMIT = 33'd1 << CFG_ADDR_W;

    state_e                  state_q, state_d;
    logic [23:0]             window_q, window_d;
    logic [15:0]             crc_q, crc_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [CFG_ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]             remaining_q, remaining_d;
    logic [CFG_ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
    logic [CFG_DATA_W-1:0]   cfg_wdata_q, cfg_wdata_d;
    logic                    cfg_valid_q, cfg_valid_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [1:0]              err_code_q, err_code_d;

    logic                    s_ready;
    logic                    s_fire;
    logic                    cfg_fire;
    logic                    last_pending;
    logic [31:0]             shifted;
    logic [15:0]             crc_next;
    logic [32:0]             hdr_end;
    logic [CFG_ADDR_W-1:0]   addr_inc;

    ozixe_crc16_byte u_crc (
        .crc_in  (crc_q),
        .data_in (bus.s_data),
        .crc_out (crc_next)
    );

    assign shifted      = {window_q, bus.s_data};
    assign s_fire       = bus.s_valid && s_ready;
    assign cfg_fire     = cfg_valid_q && bus.cfg_ready;
    assign last_pending = cfg_valid_q && (remaining_q == 16'd1);
    assign hdr_end      = 33'(shifted[31:16]) + 33'(shifted[15:0]);
    assign addr_inc     = addr_q + CFG_ADDR_W'(1);

    // While the last word is pending, the next byte is a CRC byte, so DATA must
    // not swallow it even during the accepting cycle.
    always_comb begin
        s_ready = 1'b0;
        if (rst_n) begin
            case (state_q)
                HUNT, HDR, CRC: s_ready = 1'b1;
                DATA:           s_ready = !cfg_valid_q || (bus.cfg_ready && !last_pending);
                default:        s_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        window_d    = window_q;
        crc_d       = crc_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        cfg_valid_d = cfg_valid_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;

        if (cfg_fire) begin
            cfg_valid_d = 1'b0;
            addr_d      = addr_inc;
            remaining_d = remaining_q - 16'd1;
        end

        case (state_q)
            HUNT: begin
                if (s_fire) begin
                    window_d = shifted[23:0];
                    if (shifted == SYNC_WORD) begin
                        state_d    = HDR;
                        crc_d      = CRC_INIT;
                        byte_cnt_d = 2'd0;
                    end
                end
            end

            HDR: begin
                if (s_fire) begin
                    window_d   = shifted[23:0];
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        addr_d      = CFG_ADDR_W'(shifted[31:16]);
                        remaining_d = shifted[15:0];
                        byte_cnt_d  = 2'd0;
                        if (hdr_end > ADDR_LIMIT) begin
                            state_d    = ERR;
                            error_d    = 1'b1;
                            err_code_d = ERR_ADDR_OVF;
                        end else if (shifted[15:0] == 16'd0) begin
                            state_d = CRC;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end

            DATA: begin
                if (s_fire) begin
                    window_d   = shifted[23:0];
                    crc_d      = crc_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        cfg_valid_d = 1'b1;
                        cfg_wdata_d = CFG_DATA_W'(shifted);
                        cfg_addr_d  = cfg_fire ? addr_inc : addr_q;
                    end
                end
                if (cfg_fire && remaining_q == 16'd1) begin
                    state_d    = CRC;
                    byte_cnt_d = 2'd0;
                end
            end

            CRC: begin
                if (s_fire) begin
                    window_d   = shifted[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd1) begin
                        byte_cnt_d = 2'd0;
                        if (shifted[15:0] == crc_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = ERR;
                            error_d    = 1'b1;
                            err_code_d = ERR_CRC;
                        end
                    end
                end
            end

            DONE, ERR: begin
                if (restart) begin
                    state_d    = HUNT;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    window_d   = '0;
                    crc_d      = CRC_INIT;
                    byte_cnt_d = 2'd0;
                end
            end

            default: state_d = HUNT;
        endcase
    end

    // Reset abandons any frame in flight; memory already written stays as is.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            window_q    <= '0;
            crc_q       <= CRC_INIT;
            byte_cnt_q  <= 2'd0;
            addr_q      <= '0;
            remaining_q <= 16'd0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            cfg_valid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            window_q    <= window_d;
            crc_q       <= crc_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            cfg_valid_q <= cfg_valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.cfg_addr  = cfg_addr_q;
    assign bus.cfg_wdata = cfg_wdata_q;
    assign bus.cfg_valid = cfg_valid_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;

endmodule
